// File: rtl/ahb_mtx_in_stage.sv
// AHB bus-matrix input stage: holds a master's address phase while the target
// output stage is busy and returns HREADYOUTS/HRESPS to the master.
module ahb_mtx_in_stage #(
  parameter int ADDR_W = 32,
  parameter int MID_W  = 4
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSELS,
  input  logic [ADDR_W-1:0] HADDRS,
  input  logic [1:0]        HTRANSS,
  input  logic              HWRITES,
  input  logic [2:0]        HSIZES,
  input  logic [2:0]        HBURSTS,
  input  logic [3:0]        HPROTS,
  input  logic [MID_W-1:0]  HMASTERS,
  input  logic              HMASTLOCKS,
  input  logic              HREADYS,
  input  logic              active_ip,
  input  logic              readyout_ip,
  input  logic              resp_ip,
  output logic              sel_ip,
  output logic [ADDR_W-1:0] addr_ip,
  output logic [1:0]        trans_ip,
  output logic              write_ip,
  output logic [2:0]        size_ip,
  output logic [2:0]        burst_ip,
  output logic [3:0]        prot_ip,
  output logic [MID_W-1:0]  master_ip,
  output logic              mastlock_ip,
  output logic              held_tran_ip,
  output logic              HREADYOUTS,
  output logic              HRESPS
);

  logic              r_hold_v;
  logic              r_dphase;
  logic              r_sel;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_trans;
  logic              r_write;
  logic [2:0]        r_size;
  logic [2:0]        r_burst;
  logic [3:0]        r_prot;
  logic [MID_W-1:0]  r_master;
  logic              r_mastlock;

  logic w_new_tran;
  logic w_accept;
  logic w_capture;

  // IDLE/BUSY are never held; only NONSEQ/SEQ set HTRANS[1]
  assign w_new_tran   = HSELS & HREADYS & HTRANSS[1];
  assign held_tran_ip = r_hold_v | w_new_tran;
  assign w_accept     = held_tran_ip & active_ip & readyout_ip;
  assign w_capture    = ~r_hold_v & w_new_tran & ~w_accept;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_hold_v <= 1'b0;
      r_dphase <= 1'b0;
    end else begin
      if (w_capture)     r_hold_v <= 1'b1;
      else if (w_accept) r_hold_v <= 1'b0;
      if (w_accept)         r_dphase <= 1'b1;
      else if (readyout_ip) r_dphase <= 1'b0;
    end
  end

  // Hold regs freeze while held so arbitration sees a stable address
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_sel      <= 1'b0;
      r_addr     <= '0;
      r_trans    <= '0;
      r_write    <= 1'b0;
      r_size     <= '0;
      r_burst    <= '0;
      r_prot     <= '0;
      r_master   <= '0;
      r_mastlock <= 1'b0;
    end else if (w_capture) begin
      r_sel      <= HSELS;
      r_addr     <= HADDRS;
      r_trans    <= HTRANSS;
      r_write    <= HWRITES;
      r_size     <= HSIZES;
      r_burst    <= HBURSTS;
      r_prot     <= HPROTS;
      r_master   <= HMASTERS;
      r_mastlock <= HMASTLOCKS;
    end
  end

  assign sel_ip      = r_hold_v ? r_sel      : HSELS;
  assign addr_ip     = r_hold_v ? r_addr     : HADDRS;
  assign trans_ip    = r_hold_v ? r_trans    : HTRANSS;
  assign write_ip    = r_hold_v ? r_write    : HWRITES;
  assign size_ip     = r_hold_v ? r_size     : HSIZES;
  assign burst_ip    = r_hold_v ? r_burst    : HBURSTS;
  assign prot_ip     = r_hold_v ? r_prot     : HPROTS;
  assign master_ip   = r_hold_v ? r_master   : HMASTERS;
  assign mastlock_ip = r_hold_v ? r_mastlock : HMASTLOCKS;

  assign HREADYOUTS = r_hold_v ? 1'b0 : (r_dphase ? readyout_ip : 1'b1);
  assign HRESPS     = (r_dphase & ~r_hold_v) ? resp_ip : 1'b0;

endmodule

// File: tb/tb_ahb_mtx_in_stage.sv
// Directed bench for ahb_mtx_in_stage: free path, contention hold, wait states,
// ERROR response, idle traffic and reset during hold / data phase.
module tb_ahb_mtx_in_stage;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSELS;
  logic [31:0] HADDRS;
  logic [1:0]  HTRANSS;
  logic        HWRITES;
  logic [2:0]  HSIZES;
  logic [2:0]  HBURSTS;
  logic [3:0]  HPROTS;
  logic [3:0]  HMASTERS;
  logic        HMASTLOCKS;
  logic        HREADYS;
  logic        active_ip;
  logic        readyout_ip;
  logic        resp_ip;
  logic        sel_ip;
  logic [31:0] addr_ip;
  logic [1:0]  trans_ip;
  logic        write_ip;
  logic [2:0]  size_ip;
  logic [2:0]  burst_ip;
  logic [3:0]  prot_ip;
  logic [3:0]  master_ip;
  logic        mastlock_ip;
  logic        held_tran_ip;
  logic        HREADYOUTS;
  logic        HRESPS;

  int tests = 0;
  int fails = 0;

  ahb_mtx_in_stage #(.ADDR_W(32), .MID_W(4)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSELS(HSELS), .HADDRS(HADDRS),
    .HTRANSS(HTRANSS), .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS),
    .HPROTS(HPROTS), .HMASTERS(HMASTERS), .HMASTLOCKS(HMASTLOCKS),
    .HREADYS(HREADYS), .active_ip(active_ip), .readyout_ip(readyout_ip),
    .resp_ip(resp_ip), .sel_ip(sel_ip), .addr_ip(addr_ip), .trans_ip(trans_ip),
    .write_ip(write_ip), .size_ip(size_ip), .burst_ip(burst_ip),
    .prot_ip(prot_ip), .master_ip(master_ip), .mastlock_ip(mastlock_ip),
    .held_tran_ip(held_tran_ip), .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Next cycle, 2 time units past the rising edge
  task automatic tick();
    @(posedge HCLK);
    #2;
  endtask

  task automatic bus_idle();
    HSELS = 1'b0; HTRANSS = 2'b00; HREADYS = 1'b1;
    HADDRS = 32'hDEAD_0000; HWRITES = 1'b0; HSIZES = 3'd0; HBURSTS = 3'd0;
    HPROTS = 4'd0; HMASTERS = 4'd0; HMASTLOCKS = 1'b0;
  endtask

  task automatic nonseq(input logic [31:0] a, input logic w);
    HSELS = 1'b1; HTRANSS = 2'b10; HREADYS = 1'b1; HADDRS = a; HWRITES = w;
  endtask

  initial begin
    HRESETn = 1'b0;
    bus_idle();
    active_ip = 1'b0; readyout_ip = 1'b1; resp_ip = 1'b0;
    HADDRS = 32'h0000_1234;
    #3;
    chk("rst_readyout", 64'(HREADYOUTS), 64'd1);
    chk("rst_resp", 64'(HRESPS), 64'd0);
    chk("rst_held", 64'(held_tran_ip), 64'd0);
    chk("rst_addr_live", 64'(addr_ip), 64'h1234);
    tick(); tick();
    HRESETn = 1'b1;
    tick();

    // 1. free path
    nonseq(32'h2000_0010, 1'b1); active_ip = 1'b1; readyout_ip = 1'b1;
    #1;
    chk("free_addr", 64'(addr_ip), 64'h2000_0010);
    chk("free_held", 64'(held_tran_ip), 64'd1);
    chk("free_write", 64'(write_ip), 64'd1);
    chk("free_ready_addr", 64'(HREADYOUTS), 64'd1);
    tick();
    bus_idle(); active_ip = 1'b0; readyout_ip = 1'b0;
    #1;
    chk("free_dph_ready0", 64'(HREADYOUTS), 64'd0);
    chk("free_not_held", 64'(held_tran_ip), 64'd0);
    readyout_ip = 1'b1;
    #1;
    chk("free_dph_ready1", 64'(HREADYOUTS), 64'd1);
    tick();

    // 2. contention: held for 3 cycles then accepted
    nonseq(32'h4000_0000, 1'b0);
    HSIZES = 3'd2; HBURSTS = 3'd3; HPROTS = 4'hA; HMASTERS = 4'd5; HMASTLOCKS = 1'b1;
    active_ip = 1'b0; readyout_ip = 1'b1;
    #1;
    chk("cont_live_addr", 64'(addr_ip), 64'h4000_0000);
    chk("cont_req", 64'(held_tran_ip), 64'd1);
    tick();
    bus_idle(); HREADYS = 1'b0; HSIZES = 3'd7; HPROTS = 4'h3; HMASTERS = 4'd9;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("cont_hold_ready", 64'(HREADYOUTS), 64'd0);
      chk("cont_hold_addr", 64'(addr_ip), 64'h4000_0000);
      chk("cont_hold_req", 64'(held_tran_ip), 64'd1);
      tick();
    end
    chk("cont_hold_ctl", {sel_ip, trans_ip, write_ip, size_ip, burst_ip, prot_ip, master_ip, mastlock_ip},
        {1'b1, 2'b10, 1'b0, 3'd2, 3'd3, 4'hA, 4'd5, 1'b1});
    active_ip = 1'b1;
    #1;
    chk("cont_acc_ready", 64'(HREADYOUTS), 64'd0);
    tick();
    active_ip = 1'b0; HREADYS = 1'b1;
    #1;
    chk("cont_released_req", 64'(held_tran_ip), 64'd0);
    chk("cont_released_addr", 64'(addr_ip), 64'hDEAD_0000);
    chk("cont_dph_ready", 64'(HREADYOUTS), 64'd1);
    tick();

    // 3. wait states 0,0,1
    nonseq(32'h3000_0000, 1'b1); active_ip = 1'b1; readyout_ip = 1'b1;
    tick();
    bus_idle(); active_ip = 1'b0; readyout_ip = 1'b0;
    #1; chk("ws_0", 64'(HREADYOUTS), 64'd0);
    tick();
    #1; chk("ws_1", 64'(HREADYOUTS), 64'd0);
    tick();
    readyout_ip = 1'b1;
    #1; chk("ws_2", 64'(HREADYOUTS), 64'd1);
    tick();
    readyout_ip = 1'b0;
    #1; chk("ws_done", 64'(HREADYOUTS), 64'd1);
    tick();

    // 4. two-cycle ERROR
    nonseq(32'h3000_0004, 1'b0); active_ip = 1'b1; readyout_ip = 1'b1;
    tick();
    bus_idle(); active_ip = 1'b0; readyout_ip = 1'b0; resp_ip = 1'b1;
    #1;
    chk("err1_resp", 64'(HRESPS), 64'd1);
    chk("err1_ready", 64'(HREADYOUTS), 64'd0);
    tick();
    readyout_ip = 1'b1;
    #1;
    chk("err2_resp", 64'(HRESPS), 64'd1);
    chk("err2_ready", 64'(HREADYOUTS), 64'd1);
    tick();
    readyout_ip = 1'b0;
    #1;
    chk("err_done_resp", 64'(HRESPS), 64'd0);
    chk("err_done_ready", 64'(HREADYOUTS), 64'd1);
    resp_ip = 1'b0; readyout_ip = 1'b1;
    tick();

    // 5. idle traffic
    HSELS = 1'b1; HTRANSS = 2'b00; active_ip = 1'b0;
    #1; chk("idle_trans_req", 64'(held_tran_ip), 64'd0);
    HTRANSS = 2'b01;
    #1; chk("busy_trans_req", 64'(held_tran_ip), 64'd0);
    tick();
    HSELS = 1'b0; HTRANSS = 2'b10;
    #1;
    chk("nosel_req", 64'(held_tran_ip), 64'd0);
    chk("idle_ready_resp", {HREADYOUTS, HRESPS}, 64'b10);
    tick();
    #1; chk("idle_no_capture", {held_tran_ip, HREADYOUTS}, 64'b01);

    // 6. reset mid-hold
    nonseq(32'h5000_0000, 1'b1); active_ip = 1'b0;
    tick();
    bus_idle(); HREADYS = 1'b0;
    #1; chk("rh_held", 64'(HREADYOUTS), 64'd0);
    HRESETn = 1'b0;
    #1;
    chk("rh_ready", 64'(HREADYOUTS), 64'd1);
    chk("rh_req", 64'(held_tran_ip), 64'd0);
    chk("rh_addr_live", 64'(addr_ip), 64'hDEAD_0000);
    tick();
    HRESETn = 1'b1; HREADYS = 1'b1;
    tick();

    // reset mid-data-phase
    nonseq(32'h6000_0000, 1'b0); active_ip = 1'b1; readyout_ip = 1'b1;
    tick();
    bus_idle(); active_ip = 1'b0; readyout_ip = 1'b0; resp_ip = 1'b1;
    #1; chk("rd_wait", {HREADYOUTS, HRESPS}, 64'b01);
    HRESETn = 1'b0;
    #1; chk("rd_cleared", {HREADYOUTS, HRESPS}, 64'b10);
    tick();
    HRESETn = 1'b1;
    tick();
    #1; chk("rd_after", {HREADYOUTS, HRESPS, held_tran_ip}, 64'b100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
